// File: rtl/vliw_bundle_packer.sv
// Issue-side packer: folds a scalar 16-bit instruction stream into two-slot VLIW bundles
// of one arithmetic op (instr1) followed by one load/store op (instr2).
module vliw_bundle_packer #(
    parameter int unsigned IDLE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [15:0] out_instr1,
    output logic [15:0] out_instr2,
    input  logic        out_ready
);

    localparam int unsigned IW = (IDLE_LIMIT > 0) ? $clog2(IDLE_LIMIT + 1) : 1;
    localparam logic [IW-1:0] IdleMax = IW'(IDLE_LIMIT);

    logic [15:0]   p1_q, p1_d, p2_q, p2_d;
    logic          has1_q, has1_d, has2_q, has2_d;
    logic          fl_q, fl_d;
    logic [IW-1:0] idle_q, idle_d;

    logic out_free, accept, is_nop, is_mem, is_arith, hazard;
    logic pend_any, close_first, idle_hit, auto_close, do_close;

    always_comb begin
        out_free = !out_valid || out_ready;
        in_ready = out_free && !fl_q;
        accept   = in_valid && in_ready;
        is_nop   = (in_instr == 16'h0000);
        // opcodes 000 and 100 are the memory class
        is_mem   = !is_nop && (in_instr[14:13] == 2'b00);
        is_arith = !is_nop && !is_mem;
        hazard   = has1_q && (in_instr[12:10] == p1_q[12:10]);
        pend_any = has1_q || has2_q;

        close_first = accept && ((is_arith && pend_any) || (is_mem && (has2_q || hazard)));
        idle_hit    = (IDLE_LIMIT != 0) && (idle_q == IdleMax);
        auto_close  = !accept && out_free && pend_any &&
                      ((has1_q && has2_q) || fl_q || idle_hit);
        do_close    = close_first || auto_close;
    end

    always_comb begin
        p1_d   = p1_q;
        p2_d   = p2_q;
        has1_d = has1_q;
        has2_d = has2_q;
        if (do_close) begin
            has1_d = 1'b0;
            has2_d = 1'b0;
        end
        if (accept && is_arith) begin
            p1_d   = in_instr;
            has1_d = 1'b1;
        end
        if (accept && is_mem) begin
            p2_d   = in_instr;
            has2_d = 1'b1;
        end

        fl_d = fl_q;
        if (flush) begin
            fl_d = 1'b1;
        end else if (fl_q && (do_close || !pend_any)) begin
            fl_d = 1'b0;
        end

        idle_d = idle_q;
        if (accept || do_close || !pend_any) begin
            idle_d = '0;
        end else if (idle_q != IdleMax) begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q   <= 16'h0000;
            p2_q   <= 16'h0000;
            has1_q <= 1'b0;
            has2_q <= 1'b0;
            fl_q   <= 1'b0;
            idle_q <= '0;
        end else begin
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            has1_q <= has1_d;
            has2_q <= has2_d;
            fl_q   <= fl_d;
            idle_q <= idle_d;
        end
    end

    // A close always wins over a dequeue: the new bundle replaces the departing one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_instr1 <= 16'h0000;
            out_instr2 <= 16'h0000;
        end else if (do_close) begin
            out_valid  <= 1'b1;
            out_instr1 <= has1_q ? p1_q : 16'h0000;
            out_instr2 <= has2_q ? p2_q : 16'h0000;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vliw_bundle_packer.sv
// Bench for vliw_bundle_packer: directed scenarios with fixed expectations, then a randomized
// run checked every cycle against a queue-based bundle model.
module tb_vliw_bundle_packer;

    localparam int IdleLimit = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'h0000;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [15:0] out_instr1, out_instr2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vliw_bundle_packer #(.IDLE_LIMIT(IdleLimit)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_instr1 (out_instr1),
        .out_instr2 (out_instr2),
        .out_ready  (out_ready)
    );

    // Reference model: pending bundle kept as a program-order list of instructions.
    logic [15:0] mq[$];
    bit          m_fl, m_ov;
    int          m_idle;
    logic [15:0] m_o1, m_o2;

    function automatic bit arith_class(input logic [15:0] x);
        return (x != 16'h0000) && (x[15:13] != 3'd0) && (x[15:13] != 3'd4);
    endfunction

    // A two-entry list is a legal bundle only as arith-then-mem with no register overlap.
    function automatic bit legal_pair(input logic [15:0] a, input logic [15:0] b);
        return arith_class(a) && !arith_class(b) && (a[12:10] != b[12:10]);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fl = 0; m_ov = 0; m_idle = 0; m_o1 = 16'h0000; m_o2 = 16'h0000;
    endtask

    task automatic model_emit();
        m_o1 = 16'h0000;
        m_o2 = 16'h0000;
        foreach (mq[i]) begin
            if (arith_class(mq[i])) m_o1 = mq[i];
            else m_o2 = mq[i];
        end
        mq.delete();
        m_ov = 1;
    endtask

    task automatic model_step();
        bit free, acc, closed, was_empty;
        free = !m_ov || out_ready;
        acc = in_valid && free && !m_fl;
        closed = 0;
        was_empty = (mq.size() == 0);
        if (acc) begin
            if (in_instr != 16'h0000) begin
                if (mq.size() == 2 || (mq.size() == 1 && !legal_pair(mq[0], in_instr))) begin
                    model_emit();
                    closed = 1;
                end
                mq.push_back(in_instr);
            end
        end else if (free && mq.size() > 0 &&
                     (mq.size() == 2 || m_fl || (IdleLimit != 0 && m_idle == IdleLimit))) begin
            model_emit();
            closed = 1;
        end
        if (!closed && out_ready) m_ov = 0;
        if (acc || closed || was_empty) m_idle = 0;
        else if (m_idle < IdleLimit) m_idle++;
        if (flush) m_fl = 1;
        else if (m_fl && (closed || was_empty)) m_fl = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; in_instr = 16'h0000; flush = 0; out_ready = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic wait_out(input int max, output bit got);
        got = 0;
        for (int i = 0; i < max && !got; i++) begin
            tick();
            if (out_valid) got = 1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_instr1 !== 16'h0000 || out_instr2 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out: got v=%b %h %h want v=0 0000 0000",
                     out_valid, out_instr1, out_instr2);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_pair();
        do_reset();
        out_ready = 1;
        in_valid = 1; in_instr = 16'hA400; tick();
        in_instr = 16'h0800; tick();
        in_valid = 0; tick();
        checks++;
        if (out_valid !== 1'b1 || out_instr1 !== 16'hA400 || out_instr2 !== 16'h0800) begin
            errors++;
            $display("FAIL pair_bundle: got v=%b %h %h want v=1 a400 0800",
                     out_valid, out_instr1, out_instr2);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pair_drop: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_hazard();
        bit got;
        do_reset();
        out_ready = 1;
        in_valid = 1; in_instr = 16'hA400; tick();
        in_instr = 16'h8400; tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_instr1 !== 16'hA400 || out_instr2 !== 16'h0000) begin
            errors++;
            $display("FAIL hazard_first: got v=%b %h %h want v=1 a400 0000",
                     out_valid, out_instr1, out_instr2);
        end
        tick();
        wait_out(8, got);
        checks++;
        if (!got || out_instr1 !== 16'h0000 || out_instr2 !== 16'h8400) begin
            errors++;
            $display("FAIL hazard_second: got v=%b %h %h want v=1 0000 8400",
                     out_valid, out_instr1, out_instr2);
        end
    endtask

    task automatic test_order();
        bit got;
        do_reset();
        out_ready = 1;
        in_valid = 1; in_instr = 16'h0800; tick();
        in_instr = 16'hC800; tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_instr1 !== 16'h0000 || out_instr2 !== 16'h0800) begin
            errors++;
            $display("FAIL order_first: got v=%b %h %h want v=1 0000 0800",
                     out_valid, out_instr1, out_instr2);
        end
        tick();
        wait_out(8, got);
        checks++;
        if (!got || out_instr1 !== 16'hC800 || out_instr2 !== 16'h0000) begin
            errors++;
            $display("FAIL order_second: got v=%b %h %h want v=1 c800 0000",
                     out_valid, out_instr1, out_instr2);
        end
    endtask

    task automatic test_idle_and_flush();
        do_reset();
        out_ready = 1;
        in_valid = 1; in_instr = 16'hA400; tick();
        in_valid = 0;
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_early: got out_valid=%b want 0 after 4 idle edges", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_instr1 !== 16'hA400 || out_instr2 !== 16'h0000) begin
            errors++;
            $display("FAIL idle_close: got v=%b %h %h want v=1 a400 0000",
                     out_valid, out_instr1, out_instr2);
        end
        do_reset();
        out_ready = 1;
        in_valid = 1; in_instr = 16'hA400; tick();
        in_valid = 0; flush = 1; tick();
        flush = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_set: got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_instr1 !== 16'hA400 || out_instr2 !== 16'h0000) begin
            errors++;
            $display("FAIL flush_close: got v=%b %h %h want v=1 a400 0000",
                     out_valid, out_instr1, out_instr2);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_backpressure();
        bit got;
        do_reset();
        in_valid = 1; in_instr = 16'hA400; tick();
        in_instr = 16'h0800; tick();
        in_valid = 0; tick();
        in_valid = 1; in_instr = 16'hC800;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr1 !== 16'hA400 ||
                out_instr2 !== 16'h0800) begin
                errors++;
                $display("FAIL stall_%0d: got rdy=%b v=%b %h %h want rdy=0 v=1 a400 0800",
                         i, in_ready, out_valid, out_instr1, out_instr2);
            end
            tick();
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got in_ready=%b want 1", in_ready);
        end
        tick();
        in_instr = 16'h0000; tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_dequeue: got out_valid=%b want 0", out_valid);
        end
        wait_out(8, got);
        checks++;
        if (!got || out_instr1 !== 16'hC800 || out_instr2 !== 16'h0000) begin
            errors++;
            $display("FAIL stall_held_instr: got v=%b %h %h want v=1 c800 0000",
                     out_valid, out_instr1, out_instr2);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1;
        in_valid = 1; in_instr = 16'hA400; tick();
        in_instr = 16'h0800; tick();
        in_instr = 16'hC800; tick();
        in_valid = 0;
        #1;
        rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_instr1 !== 16'h0000 || out_instr2 !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got v=%b %h %h want v=0 0000 0000",
                     out_valid, out_instr1, out_instr2);
        end
        @(negedge clk);
        rst_n = 1;
        in_valid = 1; in_instr = 16'hA400; flush = 1; tick();
        in_valid = 0; flush = 0; tick();
        checks++;
        if (out_valid !== 1'b1 || out_instr1 !== 16'hA400 || out_instr2 !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_pack: got v=%b %h %h want v=1 a400 0000",
                     out_valid, out_instr1, out_instr2);
        end
    endtask

    task automatic test_random();
        logic exp_rdy;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            out_ready = ($urandom_range(9) < 7);
            in_valid = ($urandom_range(9) < 7);
            flush = ($urandom_range(15) == 0);
            if ($urandom_range(7) == 0) in_instr = 16'h0000;
            else in_instr = {3'($urandom_range(7)), 3'($urandom_range(3)), 10'($urandom)};
            #1;
            exp_rdy = (!m_ov || out_ready) && !m_fl;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_in_ready@%0d: got %b want %b", n, in_ready, exp_rdy);
            end
            @(posedge clk);
            model_step();
            #1;
            checks++;
            if (out_valid !== m_ov || out_instr1 !== m_o1 || out_instr2 !== m_o2) begin
                errors++;
                $display("FAIL rand_out@%0d: got v=%b %h %h want v=%b %h %h", n,
                         out_valid, out_instr1, out_instr2, m_ov, m_o1, m_o2);
            end
        end
        in_valid = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_pair();
        test_hazard();
        test_order();
        test_idle_and_flush();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
